decoder_nto2n_seq: RTL

- Parametrised registered N-to-2^N one-hot decoder. It is the successor to the fixed 3-to-8 combinational decoder.
- Adds two things the combinational decoder does not have: a clocked direct-decode mode, and an autonomous scan mode that steps the active output through every line with a programmable dwell time.
- Used for digit/row scanning and one-hot select generation. It sits between control logic and the display or bank-select drivers.

---
 rtl/decoder_nto2n_seq_if.sv | 26 ++
 rtl/decoder_nto2n_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq_if.sv
// Control and decoded-output bundle for decoder_nto2n_seq.
// The master drives the controls; the decoder (slave) drives the one-hot result.
interface decoder_nto2n_seq_if #(
    parameter int N       = 3,
    parameter int DWELL_W = 8
);
    logic                 en;
    logic                 mode;
    logic [N-1:0]         sel;
    logic                 start;
    logic [DWELL_W-1:0]   dwell;
    logic [(1<<N)-1:0]    D;
    logic [N-1:0]         idx;
    logic                 valid;
    logic                 wrap;

    modport master (
        output en, mode, sel, start, dwell,
        input  D, idx, valid, wrap
    );

    modport slave (
        input  en, mode, sel, start, dwell,
        output D, idx, valid, wrap
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a direct mode and an autonomous
// scan mode that walks the active line through every output with a dwell time.
module decoder_nto2n_seq #(
    parameter int N          = 3,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_nto2n_seq_if.slave  bus
);
    localparam int          W       = 1 << N;
    localparam logic [N-1:0] IDX_MAX = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Polarity is applied here so D comes straight from a flop.
    function automatic logic [W-1:0] line_pattern(input logic [N-1:0] i, input logic v);
        logic [W-1:0] oh;
        if (v) begin
            oh = {{(W-1){1'b0}}, 1'b1} << i;
        end else begin
            oh = {W{1'b0}};
        end
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    state_t               state_q, state_d;
    logic [W-1:0]         d_q, d_d;
    logic [N-1:0]         idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    // Next-state and next-output evaluation in priority order.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (!bus.en) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else if (!bus.mode) begin
            state_d = DIRECT;
            idx_d   = bus.sel;
            valid_d = 1'b1;
        end else if (state_q != SCAN) begin
            if (bus.start) begin
                state_d = SCAN;
                idx_d   = {N{1'b0}};
                valid_d = 1'b1;
                cnt_d   = bus.dwell;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b1;
            if (cnt_q != {DWELL_W{1'b0}}) begin
                cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
            end else if (idx_q != IDX_MAX) begin
                idx_d = idx_q + {{(N-1){1'b0}}, 1'b1};
                cnt_d = bus.dwell;
            end else begin
                idx_d  = {N{1'b0}};
                cnt_d  = bus.dwell;
                wrap_d = 1'b1;
            end
        end
        d_d = line_pattern(idx_d, valid_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= line_pattern({N{1'b0}}, 1'b0);
            idx_q   <= {N{1'b0}};
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= {DWELL_W{1'b0}};
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.D     = d_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule
